// File: rtl/bubble_sort_pkg.sv
// bubble_sort_pkg: shared query encodings and default element width for the bubble-sort datapath
package bubble_sort_pkg;
    localparam int WIDTH_DEF = 8;
    localparam logic [1:0] SEL_AB  = 2'b00;
    localparam logic [1:0] SEL_BC  = 2'b01;
    localparam logic [1:0] SEL_CD  = 2'b10;
    localparam logic [1:0] SEL_CNT = 2'b11;
endpackage

// File: rtl/sort_pass_counter.sv
// sort_pass_counter: saturating down-counter of remaining sort passes with a nonzero flag
module sort_pass_counter #(
    parameter int PASSES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic dec,
    output logic nonzero
);
    localparam int CW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PASSES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign nonzero = cnt_q != '0;
    // reload beats decrement; decrement stops at zero instead of wrapping
    always_comb cnt_d = reload ? RELOAD : (dec && nonzero) ? cnt_q - CW'(1) : cnt_q;
    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/bubble_sort_datapath.sv
// bubble_sort_datapath: four-element register file answering controller compares and applying guarded swaps
module bubble_sort_datapath
    import bubble_sort_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter bit SIGNED = 1'b0,
    parameter int PASSES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic [WIDTH-1:0] din_c,
    input  logic [WIDTH-1:0] din_d,
    input  logic [1:0]       select,
    input  logic             swapAB,
    input  logic             swapBC,
    input  logic             swapCD,
    input  logic             countON,
    output logic             comp,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic [WIDTH-1:0] dout_c,
    output logic [WIDTH-1:0] dout_d,
    output logic [7:0]       swap_cnt
);
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    logic [7:0] swap_cnt_q, swap_cnt_d;
    logic nonzero, do_ab, do_bc, do_cd;

    function automatic logic gt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return SIGNED ? ($signed(x) > $signed(y)) : (x > y);
    endfunction

    sort_pass_counter #(.PASSES(PASSES)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .reload (load | countON),
        .dec    (select == SEL_CNT),
        .nonzero(nonzero)
    );

    always_comb comp = (select == SEL_AB) ? gt(a_q, b_q) :
                       (select == SEL_BC) ? gt(b_q, c_q) :
                       (select == SEL_CD) ? gt(c_q, d_q) : nonzero;

    // a swap needs the strobe, the matching query and a true compare, so stale strobes are harmless
    assign do_ab = swapAB && select == SEL_AB && comp;
    assign do_bc = swapBC && select == SEL_BC && comp;
    assign do_cd = swapCD && select == SEL_CD && comp;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        if (load) begin
            a_d = din_a;
            b_d = din_b;
            c_d = din_c;
            d_d = din_d;
        end else if (do_ab) begin
            a_d = b_q;
            b_d = a_q;
        end else if (do_bc) begin
            b_d = c_q;
            c_d = b_q;
        end else if (do_cd) begin
            c_d = d_q;
            d_d = c_q;
        end
    end

    always_comb swap_cnt_d = load ? 8'd0 :
                             ((do_ab || do_bc || do_cd) && swap_cnt_q != 8'hff) ? swap_cnt_q + 8'd1 :
                             swap_cnt_q;

    always_ff @(posedge clk)
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
            swap_cnt_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            d_q <= d_d;
            swap_cnt_q <= swap_cnt_d;
        end

    assign dout_a   = a_q;
    assign dout_b   = b_q;
    assign dout_c   = c_q;
    assign dout_d   = d_q;
    assign swap_cnt = swap_cnt_q;
endmodule

// File: doc/bubble_sort_datapath.md
# bubble_sort_datapath

Register-file datapath that executes the bubble-sort controller's commands on four WIDTH-bit elements A–D. It holds the elements and the pass counter, answers every controller query on `comp`, and applies swap strobes. It sits beside the controller: the controller drives `select`, `swapAB/BC/CD` and `countON`, and this block returns `comp`.

## Interface
- `WIDTH`, default 8: element width in bits.
- `SIGNED`, default 0: 1 selects two's-complement comparison; 0 selects unsigned.
- `PASSES`, default 3: number of full passes (N−1 for N=4); the counter reloads to `PASSES-1`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: on the edge, capture `din_a..din_d` into A..D.
- `din_a`, `din_b`, `din_c`, `din_d` in WIDTH: unsorted input elements.
- `select` in 2: query. 00 = A>B, 01 = B>C, 10 = C>D, 11 = pass counter ≠ 0.
- `swapAB`, `swapBC`, `swapCD` in 1: swap requests, level-sampled.
- `countON` in 1: reload the pass counter.
- `comp` out 1: combinational answer to `select`.
- `dout_a`, `dout_b`, `dout_c`, `dout_d` out WIDTH: registered A..D.
- `swap_cnt` out 8: number of swaps performed since load; saturates at 255.

## Operation
- Compare: strict greater-than between the adjacent pair chosen by `select`. Equal values give `comp`=0, so equal elements never swap (stable sort).
- Guarded swap: pair XY exchanges on the edge only when all three hold:
  - `swapXY`=1
  - `select` addresses XY
  - `comp`=1
- Consequences of the guard:
  - A strobe held for several cycles, or left asserted stale, swaps at most once, because `comp` drops after the swap.
  - At most one pair can qualify in a cycle, because `select` names one pair.
- Pass counter, 2 bits (sized `$clog2(PASSES)`, min 1):
  - `countON` loads `PASSES-1`.
  - Otherwise, with `select`=11 and counter ≠ 0, it decrements once per cycle.
  - It saturates at 0.
  - With `select`=11, `comp` = (counter ≠ 0), evaluated before the decrement.
- `load` actions:
  - Writes A..D.
  - Loads the counter with `PASSES-1`.
  - Clears `swap_cnt`.
- Priority per edge: `rst` > `load` > `countON` > decrement.
  - `load` overrides any swap in the same cycle.
  - `countON` overrides a decrement in the same cycle.
- `swap_cnt` increments on every performed swap and saturates at 255.

## Timing
- Reset values:
  - A..D = 0
  - pass counter = 0
  - `swap_cnt` = 0
  - `comp` = 0 for every `select`, since all registers are equal and the counter is 0
- `comp` is combinational from the registers and `select`, valid in the same cycle. The controller samples it at the edge that follows.
- A swap, load or counter update is visible on the outputs one cycle after the qualifying edge.
- Latency from load to first valid `comp` is 1 cycle.
- `rst` asserted mid-sort: all state returns to its reset value on that edge, with no partial swap.
- X on `select` after controller reset: the block's behaviour is bounded by the guard and saturation rules, with no wrap-around.

## Structure
- Package `bubble_sort_pkg` holds:
  - `SEL_AB`=2'b00, `SEL_BC`=2'b01, `SEL_CD`=2'b10, `SEL_CNT`=2'b11
  - the `WIDTH` default
- Sub-module `sort_pass_counter` contains:
  - load / decrement / saturate logic
  - the `nonzero` flag
- The top level contains:
  - the element registers
  - the compare mux
  - the swap guard
  - `swap_cnt`

## Test plan
- Reset, then `select`=11 and 00 → `comp`=0, `dout`=0,0,0,0, `swap_cnt`=0.
- Load 9,3,7,1 with `select`=00 → `comp`=1. Hold `swapAB`=1 for 3 cycles → `dout`=3,9,7,1, `swap_cnt`=1 (single swap).
- Stale strobe: `swapAB`=1 with `select`=01 on data 3,9,7,1 → no change. `swapBC`=1 with `select`=01 → 3,7,9,1.
- Load 5,5,2,8, `select`=00, `swapAB`=1 → `comp`=0, no swap, `swap_cnt`=0.
- Counter: `countON` for 1 cycle, then `select`=11 for 5 cycles → `comp` = 1,1,0,0,0. `countON` and `select`=11 in the same cycle → counter = 2, no decrement.
- Full sort with a behavioural controller model:
  - load 4,3,2,1 → `dout`=1,2,3,4, `swap_cnt`=6
  - load 1,2,3,4 → `swap_cnt`=0
  - `rst` mid-sort → all outputs 0 on the next cycle
